bt_cmd_ctrl: RTL and testbench
==============================

Name: bt_cmd_ctrl

Overview:
- Frame parser and sequencer between the UART receiver (rx_done/data byte stream) and the car motion/speed logic.
- Collects ASCII command frames of the form '$' CMD digits '#', e.g. "$F1234#".
- Validates each frame and issues one command strobe with a decoded code and a binary value.
- Resynchronises on bad characters, overlong frames and inter-byte timeouts, and reports each error with a code.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 20, maximum gap between bytes inside a frame, in ms; TIMEOUT_CYC = CLK_FREQ/1000*TIMEOUT_MS.
- MAX_DIGITS, 4, maximum number of decimal digits per frame (1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_done  in  1  one-cycle strobe: data holds a new received byte.
- data  in  8  received byte, valid only while rx_done=1.
- cmd_valid  out  1  one-cycle pulse: a new command is complete.
- cmd_code  out  3  0 STOP 'S', 1 FWD 'F', 2 BACK 'B', 3 LEFT 'L', 4 RIGHT 'R', 5 SPEED 'V'; held until the next cmd_valid.
- cmd_value  out  16  binary value of the digit field (0..9999); held until the next cmd_valid.
- err  out  1  one-cycle pulse: a frame was discarded.
- err_code  out  2  0 bad char, 1 too many digits, 2 timeout, 3 checksum; held until the next err.
- busy  out  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulator, digit count and timeout counter cleared. Reset mid-frame discards the frame with no err pulse.
- A byte is consumed only on a cycle with rx_done=1. Bytes arriving while in IDLE that are not '$' (0x24) are ignored with no error.
- State IDLE: '$' moves to CMD, clears the accumulator and digit count, and loads the timeout counter.
- State CMD: a valid command letter (uppercase only) latches a pending code and moves to DIG. '$' stays in CMD (restart). Any other byte: err code 0, go to IDLE.
- State DIG, byte 0x30..0x39:
  - If digit count < MAX_DIGITS: acc <= acc*10 + (data-0x30), count++.
  - Otherwise: err code 1, go to IDLE.
- State DIG, '#' with count >= 1: go to DONE.
- State DIG, '#' with count = 0: err code 0, go to IDLE.
- State DIG, '$': restart into CMD. No error is raised.
- State DIG, any other byte: err code 0, go to IDLE.
- State DONE: lasts one cycle. cmd_valid=1; cmd_code and cmd_value are updated in the same cycle; return to IDLE.
- Latency: cmd_valid is asserted exactly 2 clk cycles after the rx_done cycle that carried '#'.
- Timeout: the counter reloads on every consumed byte while the FSM is outside IDLE. It decrements every cycle while outside IDLE. On reaching 0: err code 2, go to IDLE.
- If rx_done and timeout expiry fall in the same cycle, the byte wins: the counter reloads and the byte is processed.
- Arithmetic: the accumulator is 14 bits, so the maximum is 9999 and there is no overflow given MAX_DIGITS <= 4. cmd_value is zero-extended to 16 bits.
- err and cmd_valid are never asserted in the same cycle.

Optional Feature:
- Macro: BT_CMD_CHECKSUM_EN.
- With the macro defined, the frame is '$' CMD digits '*' K '#'.
  - K is an ASCII digit equal to (sum of the digit values) mod 10.
  - Added states: CHK (after '*') and END (expects '#').
  - A K mismatch raises err code 3. A wrong byte in place of '*', K or '#' raises err code 0.
  - Example: "$F1234*0#" is accepted.
- Without the macro, '*' is treated as a bad char, and err code 3 is never produced.

Decomposition:
- Package bt_cmd_pkg holds:
  - ASCII constants: SOF 0x24, EOF 0x23, SEP 0x2A, DIG0 0x30.
  - Command code localparams and the letter-to-code mapping.
  - Error code localparams.
  - FSM state encoding.
- One sub-module, bt_timeout_cnt: loadable down-counter with inputs load and run, parameter TIMEOUT_CYC, and an expire pulse output.

Test Plan:
- "$F1234#" sent byte by byte -> cmd_valid pulse; cmd_code=1, cmd_value=1234; busy drops after DONE.
- "xx$V7#" -> leading junk ignored; cmd_code=5, cmd_value=7; no err.
- "$L12345#" -> err=1, err_code=1 on the 5th digit; no cmd_valid. A following "$S0#" gives cmd_code=0, cmd_value=0.
- "$R12", then no bytes for TIMEOUT_CYC cycles -> err_code=2, busy=0. A byte landing exactly on the expiry cycle instead continues the frame.
- "$B9$F42#" -> restart with no err; cmd_code=1, cmd_value=42. Asserting rst_n=0 mid-frame clears all outputs.
- BT_CMD_CHECKSUM_EN: "$F1234*0#" -> accepted with cmd_value=1234; "$F1234*5#" -> err_code=3, no cmd_valid.

Source files
------------

// File: rtl/bt_cmd_pkg.sv
// Shared constants, codes and FSM encoding for the Bluetooth command frame parser.
package bt_cmd_pkg;

  // ASCII framing characters
  localparam logic [7:0] SOF  = 8'h24;  // '$'
  localparam logic [7:0] EOF  = 8'h23;  // '#'
  localparam logic [7:0] SEP  = 8'h2A;  // '*'
  localparam logic [7:0] DIG0 = 8'h30;  // '0'
  localparam logic [7:0] DIG9 = 8'h39;  // '9'

  // Command codes
  localparam logic [2:0] CMD_STOP  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_BACK  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_SPEED = 3'd5;

  // Error codes
  localparam logic [1:0] ERR_BAD_CHAR = 2'd0;
  localparam logic [1:0] ERR_TOO_MANY = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  // Parser states; CHK and END are only reachable in the checksum build
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DIG,
    ST_CHK,
    ST_END,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } cmd_lookup_t;

  // Uppercase command letter to command code; valid=0 for anything else
  function automatic cmd_lookup_t letter_to_code(input logic [7:0] c);
    cmd_lookup_t r;
    r.valid = 1'b1;
    r.code  = CMD_STOP;
    case (c)
      8'h53:   r.code = CMD_STOP;   // 'S'
      8'h46:   r.code = CMD_FWD;    // 'F'
      8'h42:   r.code = CMD_BACK;   // 'B'
      8'h4C:   r.code = CMD_LEFT;   // 'L'
      8'h52:   r.code = CMD_RIGHT;  // 'R'
      8'h56:   r.code = CMD_SPEED;  // 'V'
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= DIG0) && (c <= DIG9);
  endfunction

endpackage

// File: rtl/bt_cmd_ctrl_timeout.sv
// Inter-byte timeout: loadable down-counter. After a load, expire is raised on the
// TIMEOUT_CYC-th following cycle if no new load has happened and run stayed high.
module bt_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_reg;

  // Reload on every consumed byte, otherwise count down to zero while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= RELOAD;
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign expire = run && !load && (cnt_reg == '0);

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Frame parser/sequencer: turns "$<CMD><digits>#" byte streams into command strobes.
// Optional build macro BT_CMD_CHECKSUM_EN adds a "*K" mod-10 checksum before '#'.
import bt_cmd_pkg::*;

module bt_cmd_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 20,
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  data,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [15:0] cmd_value,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam logic [2:0] MAX_D = 3'(MAX_DIGITS);

  state_t       state_reg, state_next;
  logic [13:0]  acc_reg, acc_next;
  logic [2:0]   cnt_reg, cnt_next;
  logic [2:0]   pend_code_reg, pend_code_next;
  logic         cmd_valid_reg, err_reg;
  logic [2:0]   cmd_code_reg;
  logic [15:0]  cmd_value_reg;
  logic [1:0]   err_code_reg;

  logic         tmo_load, tmo_expire;
  logic         err_fire, done_fire;
  logic [1:0]   err_kind;
  logic [3:0]   dig_val;
  cmd_lookup_t  lookup;

`ifdef BT_CMD_CHECKSUM_EN
  logic [3:0]   sum_reg, sum_next, sum_inc;
  logic [4:0]   sum_tmp;
`endif

  bt_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmo_load),
    .run    (state_reg != ST_IDLE),
    .expire (tmo_expire)
  );

  // Parser state and frame accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      pend_code_reg <= CMD_STOP;
`ifdef BT_CMD_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      pend_code_reg <= pend_code_next;
`ifdef BT_CMD_CHECKSUM_EN
      sum_reg       <= sum_next;
`endif
    end
  end

  // Next-state logic: one byte is examined per rx_done; a byte beats a same-cycle timeout
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    pend_code_next = pend_code_reg;
    tmo_load       = 1'b0;
    err_fire       = 1'b0;
    err_kind       = ERR_BAD_CHAR;
    done_fire      = 1'b0;
    lookup         = letter_to_code(data);
    dig_val        = 4'(data - DIG0);
`ifdef BT_CMD_CHECKSUM_EN
    sum_next       = sum_reg;
    sum_tmp        = {1'b0, sum_reg} + {1'b0, dig_val};
    sum_inc        = (sum_tmp >= 5'd10) ? 4'(sum_tmp - 5'd10) : sum_tmp[3:0];
`endif

    case (state_reg)
      ST_IDLE: begin
        if (rx_done && (data == SOF)) begin
          state_next = ST_CMD;
          acc_next   = '0;
          cnt_next   = '0;
          tmo_load   = 1'b1;
`ifdef BT_CMD_CHECKSUM_EN
          sum_next   = '0;
`endif
        end
      end

      ST_CMD: begin
        if (rx_done) begin
          tmo_load = 1'b1;
          if (lookup.valid) begin
            pend_code_next = lookup.code;
            state_next     = ST_DIG;
          end else if (data != SOF) begin
            err_fire   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (tmo_expire) begin
          err_fire   = 1'b1;
          err_kind   = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end

      ST_DIG: begin
        if (rx_done) begin
          tmo_load = 1'b1;
          if (is_digit(data)) begin
            if (cnt_reg < MAX_D) begin
              acc_next = acc_reg * 14'd10 + {10'd0, dig_val};
              cnt_next = cnt_reg + 3'd1;
`ifdef BT_CMD_CHECKSUM_EN
              sum_next = sum_inc;
`endif
            end else begin
              err_fire   = 1'b1;
              err_kind   = ERR_TOO_MANY;
              state_next = ST_IDLE;
            end
          end else if (data == SOF) begin
            // Restart: a fresh '$' abandons the partial frame silently
            state_next = ST_CMD;
            acc_next   = '0;
            cnt_next   = '0;
`ifdef BT_CMD_CHECKSUM_EN
            sum_next   = '0;
          end else if ((data == SEP) && (cnt_reg != 3'd0)) begin
            state_next = ST_CHK;
`else
          end else if ((data == EOF) && (cnt_reg != 3'd0)) begin
            state_next = ST_DONE;
`endif
          end else begin
            err_fire   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (tmo_expire) begin
          err_fire   = 1'b1;
          err_kind   = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end

`ifdef BT_CMD_CHECKSUM_EN
      ST_CHK: begin
        if (rx_done) begin
          tmo_load   = 1'b1;
          state_next = ST_IDLE;
          err_fire   = 1'b1;
          if (!is_digit(data)) begin
            err_kind = ERR_BAD_CHAR;
          end else if (dig_val != sum_reg) begin
            err_kind = ERR_CHECKSUM;
          end else begin
            err_fire   = 1'b0;
            state_next = ST_END;
          end
        end else if (tmo_expire) begin
          err_fire   = 1'b1;
          err_kind   = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end

      ST_END: begin
        if (rx_done) begin
          tmo_load = 1'b1;
          if (data == EOF) begin
            state_next = ST_DONE;
          end else begin
            err_fire   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (tmo_expire) begin
          err_fire   = 1'b1;
          err_kind   = ERR_TIMEOUT;
          state_next = ST_IDLE;
        end
      end
`endif

      ST_DONE: begin
        done_fire  = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Registered result/error strobes; codes and value hold until the next strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= '0;
      cmd_value_reg <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      cmd_valid_reg <= done_fire;
      err_reg       <= err_fire;
      if (done_fire) begin
        cmd_code_reg  <= pend_code_reg;
        cmd_value_reg <= {2'b00, acc_reg};
      end
      if (err_fire) begin
        err_code_reg <= err_kind;
      end
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_code  = cmd_code_reg;
  assign cmd_value = cmd_value_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Testbench for bt_cmd_ctrl: directed scenarios plus randomized frame streams
// checked against a string-level frame model.
module tb_bt_cmd_ctrl;

  localparam int CLK_FREQ   = 50_000;
  localparam int TIMEOUT_MS = 1;
  localparam int MAX_DIGITS = 4;
  localparam int TCYC       = CLK_FREQ / 1000 * TIMEOUT_MS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [15:0] cmd_value;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  bt_cmd_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_MS (TIMEOUT_MS),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .data      (data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_value (cmd_value),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit v;
    bit e;
    int code;
    int value;
    int cyc;
    bit busy;
  } ev_t;

  typedef struct {
    bit e;
    int code;
    int value;
  } exp_t;

  ev_t        ev_q[$];
  exp_t       exp_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] m_fb[$];
  bit         m_inf = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         last_strobe = 0;

  // Observe every output strobe on the falling edge
  always @(negedge clk) begin
    if (cmd_valid || err)
      ev_q.push_back('{cmd_valid, err, cmd_valid ? int'(cmd_code) : int'(err_code),
                       int'(cmd_value), cyc, busy});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (whole-frame text rules) ----------------
  function automatic bit is_dig(input logic [7:0] b);
    return (b >= "0") && (b <= "9");
  endfunction

  function automatic int lcode(input logic [7:0] b);
    case (b)
      "S": return 0;
      "F": return 1;
      "B": return 2;
      "L": return 3;
      "R": return 4;
      "V": return 5;
      default: return -1;
    endcase
  endfunction

  // A '$' silently restarts while the text after the last '$' is "" or letter+digits
  function automatic bit restartable(input logic [7:0] f[$]);
    if (f.size() == 0) return 1'b1;
    if (lcode(f[0]) < 0) return 1'b0;
    for (int i = 1; i < f.size(); i++)
      if (!is_dig(f[i])) return 1'b0;
    return 1'b1;
  endfunction

  // Verdict on the text after '$': 0 incomplete, 1 accepted (code/value), 2 rejected (code)
  function automatic int judge(input logic [7:0] f[$], output int code, output int value);
    int n;
    int sum;
    code  = 0;
    value = 0;
    n     = 0;
    sum   = 0;
    if (f.size() == 0) return 0;
    if (lcode(f[0]) < 0) return 2;
    while ((1 + n < f.size()) && is_dig(f[1 + n])) begin
      if (n < MAX_DIGITS) value = value * 10 + int'(f[1 + n]) - 48;
      sum = sum + int'(f[1 + n]) - 48;
      n++;
    end
    if (n > MAX_DIGITS) begin code = 1; return 2; end
    if (1 + n == f.size()) return 0;
`ifdef BT_CMD_CHECKSUM_EN
    if ((f[1 + n] != "*") || (n == 0)) return 2;
    if (f.size() == n + 2) return 0;
    if (!is_dig(f[n + 2])) return 2;
    if (int'(f[n + 2]) - 48 != sum % 10) begin code = 3; return 2; end
    if (f.size() == n + 3) return 0;
    if (f[n + 3] != "#") return 2;
    code = lcode(f[0]);
    return 1;
`else
    if ((f[1 + n] == "#") && (n >= 1)) begin
      code = lcode(f[0]);
      return 1;
    end
    return 2;
`endif
  endfunction

  task automatic model_feed(input logic [7:0] b);
    int r, c, v;
    if (!m_inf) begin
      if (b == "$") begin
        m_inf = 1'b1;
        m_fb.delete();
      end
      return;
    end
    if ((b == "$") && restartable(m_fb)) begin
      m_fb.delete();
      return;
    end
    m_fb.push_back(b);
    r = judge(m_fb, c, v);
    if (r == 1) begin
      exp_q.push_back('{1'b0, c, v});
      m_inf = 1'b0;
    end else if (r == 2) begin
      exp_q.push_back('{1'b1, c, 0});
      m_inf = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called right after a falling edge: one rx_done cycle followed by gap idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_done     = 1'b1;
    data        = b;
    last_strobe = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    data    = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_modeled(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      model_feed(s[i]);
      send_byte(s[i], gap);
    end
  endtask

  task automatic start_scenario(output int base);
    base = ev_q.size();
    exp_q.delete();
    m_inf = 1'b0;
    m_fb.delete();
  endtask

  task automatic check_events(input string name, input int base);
    int n;
    ev_t  a;
    exp_t x;
    repeat (4) @(negedge clk);
    n = ev_q.size() - base;
    checks++;
    if (n != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d required %0d", name, n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      a = ev_q[base + i];
      x = exp_q[i];
      checks++;
      if ((a.v && a.e) || (a.e != x.e) || (a.code != x.code) || (!x.e && a.value != x.value)) begin
        errors++;
        $display("FAIL %s event%0d: got valid=%0d err=%0d code=%0d value=%0d required err=%0d code=%0d value=%0d",
                 name, i, a.v, a.e, a.code, a.value, x.e, x.code, x.value);
      end else begin
        $display("  %s event%0d ok: err=%0d code=%0d value=%0d", name, i, a.e, a.code, a.value);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_code, cmd_value, err, err_code, busy} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 000000",
               {cmd_valid, cmd_code, cmd_value, err, err_code, busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_valid, err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL after_reset_idle: got %b required 000", {cmd_valid, err, busy});
    end
    $display("  reset checked");
  endtask

  task automatic test_basic();
    int base, t_hash;
    start_scenario(base);
    send_modeled("$", 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: got %b required 1", busy);
    end
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("F1234*0", 2);
`else
    send_modeled("F1234", 2);
`endif
    model_feed("#");
    send_byte("#", 0);
    t_hash = last_strobe;
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() <= base) begin
      errors++;
      $display("FAIL basic_latency: got no cmd_valid required one at cycle %0d", t_hash + 2);
    end else if ((ev_q[base].cyc != t_hash + 2) || (ev_q[base].busy !== 1'b0)) begin
      errors++;
      $display("FAIL basic_latency: got cycle %0d busy %0d required cycle %0d busy 0",
               ev_q[base].cyc, ev_q[base].busy, t_hash + 2);
    end
    check_events("basic", base);
  endtask

  task automatic test_junk();
    int base;
    start_scenario(base);
    send_modeled("xx", 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_idle_busy: got %b required 0", busy);
    end
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("$V7*7#", 1);
`else
    send_modeled("$V7#", 1);
`endif
    check_events("junk", base);
  endtask

  task automatic test_too_many();
    int base;
    start_scenario(base);
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("$L12345#$S0*0#", 1);
`else
    send_modeled("$L12345#$S0#", 1);
`endif
    check_events("too_many", base);
  endtask

  task automatic test_separator();
    int base;
    start_scenario(base);
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("$F1234*0#$F1234*5#$B*1#", 1);
`else
    send_modeled("$F12*3#$F#$f1#", 1);
`endif
    check_events("separator", base);
  endtask

  task automatic test_timeout();
    int base, t_last;
    // Silence after "$R12": timeout error TCYC cycles after the last byte
    start_scenario(base);
    send_byte("$", 1);
    send_byte("R", 1);
    send_byte("1", 1);
    send_byte("2", TCYC + 5);
    t_last = last_strobe;
    exp_q.push_back('{1'b1, 2, 0});
    checks++;
    if (ev_q.size() <= base) begin
      errors++;
      $display("FAIL timeout_timing: got no err required one at cycle %0d", t_last + TCYC + 1);
    end else if ((ev_q[base].cyc != t_last + TCYC + 1) || (ev_q[base].busy !== 1'b0)) begin
      errors++;
      $display("FAIL timeout_timing: got cycle %0d busy %0d required cycle %0d busy 0",
               ev_q[base].cyc, ev_q[base].busy, t_last + TCYC + 1);
    end
    check_events("timeout", base);
    // Every byte lands exactly on the expiry cycle: frame survives
    start_scenario(base);
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("$R12*3", TCYC - 1);
`else
    send_modeled("$R12", TCYC - 1);
`endif
    send_modeled("#", 1);
    check_events("timeout_edge", base);
  endtask

  task automatic test_restart_reset();
    int base;
    start_scenario(base);
`ifdef BT_CMD_CHECKSUM_EN
    send_modeled("$B9$F42*6#", 1);
`else
    send_modeled("$B9$F42#", 1);
`endif
    check_events("restart", base);
    start_scenario(base);
    send_byte("$", 1);
    send_byte("R", 1);
    send_byte("5", 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, cmd_code, cmd_value, err, err_code, busy} !== 24'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %h required 000000",
               {cmd_valid, cmd_code, cmd_value, err, err_code, busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TCYC + 10) @(negedge clk);
    check_events("reset_discard", base);
  endtask

  task automatic gen_fragment();
    string letters = "SFBLRV";
    string junk    = "x#*9a";
    int kind, n, sum;
    kind = $urandom_range(0, 6);
    case (kind)
      0, 1, 2: begin
        n   = (kind == 2) ? $urandom_range(5, 6) : $urandom_range(1, 4);
        sum = 0;
        stim_q.push_back("$");
        stim_q.push_back(letters[$urandom_range(0, 5)]);
        for (int i = 0; i < n; i++) begin
          int d = $urandom_range(0, 9);
          sum += d;
          stim_q.push_back(8'(48 + d));
        end
`ifdef BT_CMD_CHECKSUM_EN
        stim_q.push_back("*");
        stim_q.push_back(8'(48 + ($urandom_range(0, 3) == 0 ? (sum + 1) % 10 : sum % 10)));
`endif
        stim_q.push_back("#");
      end
      3: begin
        stim_q.push_back("$");
        stim_q.push_back($urandom_range(0, 1) ? "f" : "Q");
        stim_q.push_back("3");
        stim_q.push_back("#");
      end
      4: stim_q.push_back(junk[$urandom_range(0, 4)]);
      5: begin
        stim_q.push_back("$");
        stim_q.push_back(letters[$urandom_range(0, 5)]);
        stim_q.push_back(8'(48 + $urandom_range(0, 9)));
      end
      default: begin
        stim_q.push_back("$");
        stim_q.push_back("F");
        stim_q.push_back($urandom_range(0, 1) ? "#" : "*");
      end
    endcase
  endtask

  task automatic test_random(input int round);
    int base;
    start_scenario(base);
    stim_q.delete();
    for (int i = 0; i < 30; i++) gen_fragment();
    foreach (stim_q[i]) begin
      model_feed(stim_q[i]);
      send_byte(stim_q[i], $urandom_range(1, 4));
    end
    if (m_inf) exp_q.push_back('{1'b1, 2, 0});
    repeat (TCYC + 10) @(negedge clk);
    check_events($sformatf("random%0d", round), base);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_junk();
    test_too_many();
    test_separator();
    test_timeout();
    test_restart_reset();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
